vctrl_ptr_seq: RTL and testbench

Loop-pointer sequencer for the vector array control path. On a start request it walks the `(colPtr, rowPtr)` iteration space, row innermost, and issues one pointer pair per cycle. The pairs feed the combinational address converter that drives the OBuf, EBuf and VBuf addresses and the OBuf bank selects. It supports downstream stall and synchronous abort. It tracks buffer read latency so that read data can be qualified and completion signalled only after the last read returns.

---
 rtl/vctrl_ptr_seq_pkg.sv | 13 +
 rtl/vctrl_valid_pipe.sv | 28 ++
 rtl/vctrl_ptr_seq.sv | 112 +++++++++++
 tb/tb_vctrl_ptr_seq.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vctrl_ptr_seq_pkg.sv
// Shared constants and FSM state type for the vector-control pointer sequencer.
package vctrl_ptr_seq_pkg;

  localparam int unsigned VRowLoop = 4;
  localparam int unsigned VColLoop = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } vseq_state_e;

endpackage

// File: rtl/vctrl_valid_pipe.sv
// Width x Depth delay line with synchronous flush and async active-low reset.
module vctrl_valid_pipe #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] stage_q [Depth];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < Depth; i++) stage_q[i] <= '0;
    end else if (flush_i) begin
      for (int unsigned i = 0; i < Depth; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int unsigned i = 1; i < Depth; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[Depth-1];

endmodule

// File: rtl/vctrl_ptr_seq.sv
// Loop-pointer sequencer: walks (colPtr,rowPtr) row-innermost, one pair per
// cycle, with stall/abort and a read-latency tracker for completion.
module vctrl_ptr_seq
  import vctrl_ptr_seq_pkg::*;
#(
  parameter int unsigned VRowLoop = vctrl_ptr_seq_pkg::VRowLoop,
  parameter int unsigned VColLoop = vctrl_ptr_seq_pkg::VColLoop,
  parameter int unsigned ReadLat  = 2,
  localparam int unsigned RowW    = $clog2(VRowLoop),
  localparam int unsigned ColW    = $clog2(VColLoop)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            stall,
  output logic [RowW-1:0] rowPtr,
  output logic [ColW-1:0] colPtr,
  output logic            ptrValid,
  output logic            ptrFire,
  output logic            ptrLast,
  output logic            rdValid,
  output logic            rdLast,
  output logic            busy,
  output logic            done
);

  localparam logic [RowW-1:0] RowMax = RowW'(VRowLoop - 1);
  localparam logic [ColW-1:0] ColMax = ColW'(VColLoop - 1);

  vseq_state_e     state_q, state_d;
  logic [RowW-1:0] row_q, row_d;
  logic [ColW-1:0] col_q, col_d;
  logic            fire_last;
  logic [1:0]      pipe_in, pipe_out;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start)     state_d = RUN;
        RUN:     if (fire_last) state_d = DRAIN;
        DRAIN:   if (done)      state_d = IDLE;
        default:                state_d = IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    busy      = (state_q != IDLE);
    ptrValid  = (state_q == RUN);
    ptrLast   = ptrValid && (row_q == RowMax) && (col_q == ColMax);
    ptrFire   = ptrValid & ~stall;
    fire_last = ptrFire & ptrLast;
    rowPtr    = row_q;
    colPtr    = col_q;
    rdValid   = pipe_out[1];
    rdLast    = pipe_out[0];
    done      = rdValid & rdLast;
  end

  // Pointers return to (0,0) on the final fire so IDLE->RUN needs no reload.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (abort || fire_last) begin
      row_d = '0;
      col_d = '0;
    end else if (ptrFire) begin
      if (row_q == RowMax) begin
        row_d = '0;
        col_d = col_q + ColW'(1);
      end else begin
        row_d = row_q + RowW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign pipe_in = {ptrFire, fire_last};

  vctrl_valid_pipe #(
    .Width(2),
    .Depth(ReadLat)
  ) u_rd_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush_i(abort),
    .d_i    (pipe_in),
    .q_o    (pipe_out)
  );

endmodule

// File: tb/tb_vctrl_ptr_seq.sv
// Bench for vctrl_ptr_seq: two builds (4x2 lat2, 2x4 lat1) against a pass-level model.
module tb_vctrl_ptr_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, stall = 1'b0, abort_a = 1'b0, abort_b = 1'b0;

  logic [1:0] a_row; logic [0:0] a_col;
  logic a_pv, a_pf, a_pl, a_rv, a_rl, a_busy, a_done;
  logic [0:0] b_row; logic [1:0] b_col;
  logic b_pv, b_pf, b_pl, b_rv, b_rl, b_busy, b_done;

  vctrl_ptr_seq #(.VRowLoop(4), .VColLoop(2), .ReadLat(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort_a), .stall(stall),
    .rowPtr(a_row), .colPtr(a_col), .ptrValid(a_pv), .ptrFire(a_pf), .ptrLast(a_pl),
    .rdValid(a_rv), .rdLast(a_rl), .busy(a_busy), .done(a_done)
  );

  vctrl_ptr_seq #(.VRowLoop(2), .VColLoop(4), .ReadLat(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort_b), .stall(stall),
    .rowPtr(b_row), .colPtr(b_col), .ptrValid(b_pv), .ptrFire(b_pf), .ptrLast(b_pl),
    .rdValid(b_rv), .rdLast(b_rl), .busy(b_busy), .done(b_done)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Vector layout: [22]busy [21]ptrValid [20]ptrFire [19]ptrLast
  // [18]rdValid [17]rdLast [16]done [15:8]colPtr [7:0]rowPtr
  logic [22:0] exp_vec [2];
  logic [22:0] obs_vec [2];
  bit   [1:0]  ab_mask = 2'b11;

  int unsigned R [2] = '{4, 2};
  int unsigned C [2] = '{2, 4};
  int unsigned L [2] = '{2, 1};
  int unsigned m_phase [2];  // 0 idle, 1 issuing, 2 waiting for reads
  int unsigned m_k [2];      // pairs fired so far in this pass
  bit [1:0]    m_sched [2][16];  // {read returns, is last} due at cycle mod 16
  int unsigned ncyc = 0;

  int unsigned glitch = 0;
  bit          rst_win = 1'b0;
  always @(posedge a_done or posedge b_done) if (rst_win) glitch++;

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_phase[d] = 0;
      m_k[d] = 0;
      for (int s = 0; s < 16; s++) m_sched[d][s] = 2'b00;
    end
  endtask

  task automatic model_cycle(input int d, input bit st, input bit ab, input bit sl);
    int unsigned n_pairs = R[d] * C[d];
    int unsigned slot = ncyc % 16;
    bit pv, pl, pf, rv, rl;
    pv = (m_phase[d] == 1);
    pl = pv && (m_k[d] == n_pairs - 1);
    pf = pv && !sl;
    rv = m_sched[d][slot][1];
    rl = m_sched[d][slot][0];
    exp_vec[d] = {m_phase[d] != 0, pv, pf, pl, rv, rl, rv && rl,
                  pv ? 8'(m_k[d] / R[d]) : 8'd0, pv ? 8'(m_k[d] % R[d]) : 8'd0};
    m_sched[d][slot] = 2'b00;
    if (ab) begin
      m_phase[d] = 0;
      m_k[d] = 0;
      for (int s = 0; s < 16; s++) m_sched[d][s] = 2'b00;
    end else begin
      case (m_phase[d])
        0: if (st) begin m_phase[d] = 1; m_k[d] = 0; end
        1: if (pf) begin
             m_sched[d][(ncyc + L[d]) % 16] = {1'b1, pl};
             if (pl) begin m_phase[d] = 2; m_k[d] = 0; end
             else m_k[d]++;
           end
        default: if (rv && rl) m_phase[d] = 0;
      endcase
    end
  endtask

  task automatic step(input bit st, input bit ab, input bit sl);
    start   = st;
    stall   = sl;
    abort_a = ab & ab_mask[0];
    abort_b = ab & ab_mask[1];
    @(negedge clk);
    obs_vec[0] = {a_busy, a_pv, a_pf, a_pl, a_rv, a_rl, a_done, 8'(a_col), 8'(a_row)};
    obs_vec[1] = {b_busy, b_pv, b_pf, b_pl, b_rv, b_rl, b_done, 8'(b_col), 8'(b_row)};
    model_cycle(0, st, ab & ab_mask[0], sl);
    model_cycle(1, st, ab & ab_mask[1], sl);
    ncyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    ab_mask = 2'b11;
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({a_busy, a_pv, a_pf, a_pl, a_rv, a_rl, a_done, a_col, a_row,
         b_busy, b_pv, b_pf, b_pl, b_rv, b_rl, b_done, b_col, b_row} !== '0) begin
      errors++;
      $display("FAIL reset_values got a=%b%b%b%b%b%b%b b=%b%b%b%b%b%b%b want all 0",
               a_busy, a_pv, a_pf, a_pl, a_rv, a_rl, a_done,
               b_busy, b_pv, b_pf, b_pl, b_rv, b_rl, b_done);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs_vec[d] !== exp_vec[d]) begin
          errors++;
          $display("FAIL reset_idle dut%0d cyc%0d got %h want %h", d, i, obs_vec[d], exp_vec[d]);
        end
      end
    end
  endtask

  task automatic test_basic();
    int fires_a = 0, done_a = -1, done_b = -1, last_b = -1;
    idle_all();
    for (int i = 0; i < 13; i++) begin
      step(i == 0, 1'b0, 1'b0);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs_vec[d] !== exp_vec[d]) begin
          errors++;
          $display("FAIL basic dut%0d cyc%0d got %h want %h", d, i, obs_vec[d], exp_vec[d]);
        end
      end
      if (obs_vec[0][20]) fires_a++;
      if (obs_vec[0][16]) done_a = i;
      if (obs_vec[1][20]) last_b = i;
      if (obs_vec[1][16]) done_b = i;
      if (i == 5) begin
        checks++;
        if (obs_vec[0][15:0] !== 16'h0100) begin
          errors++;
          $display("FAIL row_wrap got col/row %h want 0100", obs_vec[0][15:0]);
        end
      end
    end
    checks++;
    if (fires_a != 8 || done_a != 10) begin
      errors++;
      $display("FAIL basic_summary got fires=%0d done@%0d want fires=8 done@10", fires_a, done_a);
    end
    checks++;
    if (last_b != 8 || done_b != 9) begin
      errors++;
      $display("FAIL alt_build got last_fire@%0d done@%0d want 8 and 9", last_b, done_b);
    end
  endtask

  task automatic test_stall();
    int fires_a = 0, done_a = -1, held = 0, last_cnt = 0;
    idle_all();
    for (int i = 0; i < 16; i++) begin
      step(i == 0, 1'b0, (i >= 2 && i <= 4));
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs_vec[d] !== exp_vec[d]) begin
          errors++;
          $display("FAIL stall dut%0d cyc%0d got %h want %h", d, i, obs_vec[d], exp_vec[d]);
        end
      end
      if (obs_vec[0][20]) fires_a++;
      if (obs_vec[0][16]) done_a = i;
      if (obs_vec[0][21] && obs_vec[0][15:0] == 16'h0001) held++;
    end
    checks++;
    if (fires_a != 8 || done_a != 13 || held != 4) begin
      errors++;
      $display("FAIL stall_summary got fires=%0d done@%0d held=%0d want 8 13 4", fires_a, done_a, held);
    end
    idle_all();
    done_a = -1;
    for (int i = 0; i < 16; i++) begin
      step(i == 0, 1'b0, (i >= 8 && i <= 10));
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs_vec[d] !== exp_vec[d]) begin
          errors++;
          $display("FAIL stall_last dut%0d cyc%0d got %h want %h", d, i, obs_vec[d], exp_vec[d]);
        end
      end
      if (obs_vec[0][19]) last_cnt++;
      if (obs_vec[0][16]) done_a = i;
    end
    checks++;
    if (last_cnt != 4 || done_a != 13) begin
      errors++;
      $display("FAIL stall_last_summary got last_cycles=%0d done@%0d want 4 13", last_cnt, done_a);
    end
  endtask

  task automatic test_abort();
    int done_seen = 0;
    idle_all();
    for (int i = 0; i < 12; i++) begin
      step(i == 0, i == 5, 1'b0);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs_vec[d] !== exp_vec[d]) begin
          errors++;
          $display("FAIL abort_run dut%0d cyc%0d got %h want %h", d, i, obs_vec[d], exp_vec[d]);
        end
      end
      if (obs_vec[0][16] || obs_vec[1][16]) done_seen++;
      if (i == 6) begin
        checks++;
        if (obs_vec[0] !== 23'h0) begin
          errors++;
          $display("FAIL abort_idle got %h want 000000", obs_vec[0]);
        end
      end
    end
    checks++;
    if (done_seen != 0) begin
      errors++;
      $display("FAIL abort_no_done got %0d done pulses want 0", done_seen);
    end
    idle_all();
    ab_mask = 2'b01;
    done_seen = 0;
    for (int i = 0; i < 14; i++) begin
      step(i == 0, i == 9, 1'b0);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs_vec[d] !== exp_vec[d]) begin
          errors++;
          $display("FAIL abort_drain dut%0d cyc%0d got %h want %h", d, i, obs_vec[d], exp_vec[d]);
        end
      end
      if (obs_vec[0][16]) done_seen++;
    end
    ab_mask = 2'b11;
    checks++;
    if (done_seen != 0) begin
      errors++;
      $display("FAIL abort_drain_no_done got %0d done pulses want 0", done_seen);
    end
  endtask

  task automatic test_start();
    int fires_a = 0;
    idle_all();
    for (int i = 0; i < 22; i++) begin
      step(i == 0 || i == 3 || i == 9 || i == 11, 1'b0, 1'b0);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs_vec[d] !== exp_vec[d]) begin
          errors++;
          $display("FAIL start dut%0d cyc%0d got %h want %h", d, i, obs_vec[d], exp_vec[d]);
        end
      end
      if (i <= 10 && obs_vec[0][20]) fires_a++;
      if (i == 12) begin
        checks++;
        if (!obs_vec[0][21] || obs_vec[0][15:0] !== 16'h0000) begin
          errors++;
          $display("FAIL restart got valid=%b pair=%h want 1 0000", obs_vec[0][21], obs_vec[0][15:0]);
        end
      end
    end
    checks++;
    if (fires_a != 8) begin
      errors++;
      $display("FAIL start_ignored got %0d fires want 8", fires_a);
    end
  endtask

  task automatic test_async_reset();
    idle_all();
    for (int i = 0; i < 4; i++) step(i == 0, 1'b0, 1'b0);
    #3;
    rst_win = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_busy, a_pv, a_pf, a_pl, a_rv, a_rl, a_done, a_col, a_row,
         b_busy, b_pv, b_pf, b_pl, b_rv, b_rl, b_done, b_col, b_row} !== '0) begin
      errors++;
      $display("FAIL async_reset got a_busy=%b a_pv=%b a_row=%h b_busy=%b b_pv=%b want 0",
               a_busy, a_pv, a_row, b_busy, b_pv);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    rst_win = 1'b0;
    model_reset();
    checks++;
    if (glitch != 0) begin
      errors++;
      $display("FAIL reset_glitch got %0d done edges want 0", glitch);
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 1'b0);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs_vec[d] !== exp_vec[d]) begin
          errors++;
          $display("FAIL post_reset dut%0d cyc%0d got %h want %h", d, i, obs_vec[d], exp_vec[d]);
        end
      end
    end
  endtask

  task automatic test_random();
    bit st, ab, sl;
    idle_all();
    for (int i = 0; i < 600; i++) begin
      st = ($urandom_range(0, 7) == 0);
      sl = ($urandom_range(0, 3) == 0);
      ab = ($urandom_range(0, 49) == 0);
      // Keep abort off the exact cycle a completion pulse is due.
      if (m_sched[0][ncyc % 16] == 2'b11 || m_sched[1][ncyc % 16] == 2'b11) ab = 1'b0;
      step(st, ab, sl);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs_vec[d] !== exp_vec[d]) begin
          errors++;
          $display("FAIL random dut%0d cyc%0d got %h want %h", d, i, obs_vec[d], exp_vec[d]);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_stall();
    test_abort();
    test_start();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
